// File: rtl/retire_trace_checker.sv
// Retirement trace checker: buffers golden retire records in a FIFO and compares each
// against the core's commit tap, reporting pass/halt, the first mismatch, and counters.
module retire_trace_checker #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [2:0]       exp_kind,
  input  logic [15:0]      exp_pc,
  input  logic [15:0]      exp_val,
  input  logic [15:0]      exp_addr,
  input  logic [15:0]      exp_mdata,
  input  logic [2:0]       exp_reg,
  input  logic             ret_valid,
  input  logic [15:0]      ret_pc,
  input  logic [15:0]      ret_wdata,
  input  logic [15:0]      ret_addr,
  input  logic [15:0]      ret_mdata,
  input  logic             ret_regwrite,
  input  logic             ret_memread,
  input  logic             ret_memwrite,
  input  logic             ret_halt,
  input  logic [2:0]       ret_wreg,
  output logic             done,
  output logic             pass,
  output logic             error,
  output logic [3:0]       err_code,
  output logic [CNT_W-1:0] err_inum,
  output logic [15:0]      err_pc,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StRun, StHalted, StError} state_e;

  state_e          r_state;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic [2:0]      r_kind_mem [DEPTH];
  logic [15:0]     r_pc_mem   [DEPTH];
  logic [15:0]     r_val_mem  [DEPTH];
  logic [15:0]     r_addr_mem [DEPTH];
  logic [15:0]     r_md_mem   [DEPTH];
  logic [2:0]      r_reg_mem  [DEPTH];

  logic            r_done, r_pass, r_error;
  logic [3:0]      r_err_code;
  logic [CNT_W-1:0] r_err_inum, r_inst_count, r_cycle_count;
  logic [15:0]     r_err_pc;

  logic            w_full, w_empty, w_push, w_pop;
  logic [2:0]      w_ret_kind, w_h_kind;
  logic            w_chk_reg, w_chk_addr, w_chk_md;
  logic [3:0]      w_code;

  assign w_full    = (r_count == DepthC);
  assign w_empty   = (r_count == '0);
  assign exp_ready = !w_full;
  // A pop frees the slot the concurrent push lands in, so a full FIFO may still take it.
  assign w_pop     = (r_state == StRun) && ret_valid && !w_empty;
  assign w_push    = exp_valid && (!w_full || w_pop) && (r_state != StError);
  assign w_h_kind  = r_kind_mem[r_rptr];

  always_comb begin
    w_ret_kind = 3'd0;
    if (ret_halt)                          w_ret_kind = 3'd5;
    else if (ret_regwrite && ret_memwrite) w_ret_kind = 3'd4;
    else if (ret_regwrite && ret_memread)  w_ret_kind = 3'd2;
    else if (ret_regwrite)                 w_ret_kind = 3'd1;
    else if (ret_memwrite)                 w_ret_kind = 3'd3;
  end

  assign w_chk_reg  = (w_h_kind == 3'd1) || (w_h_kind == 3'd2) || (w_h_kind == 3'd4);
  assign w_chk_addr = (w_h_kind == 3'd2) || (w_h_kind == 3'd3) || (w_h_kind == 3'd4);
  assign w_chk_md   = (w_h_kind == 3'd3) || (w_h_kind == 3'd4);

  always_comb begin
    w_code = 4'd0;
    if (w_empty)                                              w_code = 4'd1;
    else if ((w_h_kind > 3'd5) || (w_h_kind != w_ret_kind))   w_code = 4'd2;
    else if (r_pc_mem[r_rptr] != ret_pc)                      w_code = 4'd3;
    else if (w_chk_reg && (r_reg_mem[r_rptr] != ret_wreg))    w_code = 4'd4;
    else if (w_chk_reg && (r_val_mem[r_rptr] != ret_wdata))   w_code = 4'd5;
    else if (w_chk_addr && (r_addr_mem[r_rptr] != ret_addr))  w_code = 4'd6;
    else if (w_chk_md && (r_md_mem[r_rptr] != ret_mdata))     w_code = 4'd7;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_kind_mem[r_wptr] <= exp_kind;
        r_pc_mem[r_wptr]   <= exp_pc;
        r_val_mem[r_wptr]  <= exp_val;
        r_addr_mem[r_wptr] <= exp_addr;
        r_md_mem[r_wptr]   <= exp_mdata;
        r_reg_mem[r_wptr]  <= exp_reg;
        r_wptr             <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StRun;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= 4'd0;
      r_err_inum    <= '0;
      r_err_pc      <= 16'd0;
      r_inst_count  <= '0;
      r_cycle_count <= '0;
    end else begin
      case (r_state)
        StRun: begin
          r_cycle_count <= r_cycle_count + CNT_W'(1);
          if (ret_valid) begin
            if (w_code == 4'd0) begin
              r_inst_count <= r_inst_count + CNT_W'(1);
              if (w_ret_kind == 3'd5) begin
                r_state <= StHalted;
                r_done  <= 1'b1;
                r_pass  <= 1'b1;
              end
            end else begin
              r_state    <= StError;
              r_error    <= 1'b1;
              r_err_code <= w_code;
              r_err_inum <= r_inst_count;
              r_err_pc   <= ret_pc;
            end
          end
        end
        StHalted: begin
          if (ret_valid) begin
            r_state    <= StError;
            r_error    <= 1'b1;
            r_pass     <= 1'b0;
            r_err_code <= 4'd8;
            r_err_inum <= r_inst_count;
            r_err_pc   <= ret_pc;
          end
        end
        StError: ;
        default: r_state <= StError;
      endcase
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign error       = r_error;
  assign err_code    = r_err_code;
  assign err_inum    = r_err_inum;
  assign err_pc      = r_err_pc;
  assign inst_count  = r_inst_count;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_retire_trace_checker.sv
// Scoreboard bench for retire_trace_checker: directed retires push expected status into a
// queue; a monitor pops and compares one cycle after every retire.
module tb_retire_trace_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        exp_valid, exp_ready;
  logic [2:0]  exp_kind, exp_reg;
  logic [15:0] exp_pc, exp_val, exp_addr, exp_mdata;
  logic        ret_valid, ret_regwrite, ret_memread, ret_memwrite, ret_halt;
  logic [15:0] ret_pc, ret_wdata, ret_addr, ret_mdata;
  logic [2:0]  ret_wreg;
  logic        done, pass, error;
  logic [3:0]  err_code;
  logic [31:0] err_inum, inst_count, cycle_count;
  logic [15:0] err_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic [3:0]  code;
    logic [31:0] inum;
    logic [15:0] epc;
    logic [31:0] inst;
    logic        dn;
    logic        ps;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  retire_trace_checker #(.DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
    .exp_pc(exp_pc), .exp_val(exp_val), .exp_addr(exp_addr), .exp_mdata(exp_mdata),
    .exp_reg(exp_reg),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_wdata(ret_wdata), .ret_addr(ret_addr),
    .ret_mdata(ret_mdata), .ret_regwrite(ret_regwrite), .ret_memread(ret_memread),
    .ret_memwrite(ret_memwrite), .ret_halt(ret_halt), .ret_wreg(ret_wreg),
    .done(done), .pass(pass), .error(error), .err_code(err_code), .err_inum(err_inum),
    .err_pc(err_pc), .inst_count(inst_count), .cycle_count(cycle_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic e, input logic [3:0] c, input logic [31:0] n,
                              input logic [15:0] p, input logic [31:0] i, input logic d,
                              input logic s);
    exp_t r;
    r.err = e; r.code = c; r.inum = n; r.epc = p; r.inst = i; r.dn = d; r.ps = s;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exp_ready", exp_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_err_inum", err_inum, 0);
    chk("rst_err_pc", err_pc, 0);
    chk("rst_inst_count", inst_count, 0);
    chk("rst_cycle_count", cycle_count, 0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic push_rec(input logic [2:0] k, input logic [15:0] pc, input logic [15:0] val,
                          input logic [15:0] ad, input logic [15:0] md, input logic [2:0] rg);
    exp_kind = k; exp_pc = pc; exp_val = val; exp_addr = ad; exp_mdata = md; exp_reg = rg;
    exp_valid = 1'b1;
    chk("push_ready", exp_ready, 1);
    @(posedge clk);
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic retire(input logic [15:0] pc, input logic [15:0] wd, input logic [15:0] ad,
                        input logic [15:0] md, input logic [2:0] wr, input logic rw,
                        input logic mr, input logic mw, input logic hl, input exp_t e);
    ret_pc = pc; ret_wdata = wd; ret_addr = ad; ret_mdata = md; ret_wreg = wr;
    ret_regwrite = rw; ret_memread = mr; ret_memwrite = mw; ret_halt = hl;
    ret_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    ret_valid = 1'b0;
    ret_regwrite = 1'b0; ret_memread = 1'b0; ret_memwrite = 1'b0; ret_halt = 1'b0;
  endtask

  // Monitor: status is visible just after the edge that sampled the retire.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (ret_valid && !rst) begin
        #1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_retire: got retire expected none");
        end else begin
          e = sb_q.pop_front();
          chk("sb_error", error, e.err);
          chk("sb_err_code", err_code, e.code);
          chk("sb_err_inum", err_inum, e.inum);
          chk("sb_err_pc", err_pc, e.epc);
          chk("sb_inst_count", inst_count, e.inst);
          chk("sb_done", done, e.dn);
          chk("sb_pass", pass, e.ps);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; exp_valid = 1'b0; exp_kind = 3'd0; exp_reg = 3'd0;
    exp_pc = 16'd0; exp_val = 16'd0; exp_addr = 16'd0; exp_mdata = 16'd0;
    ret_valid = 1'b0; ret_regwrite = 1'b0; ret_memread = 1'b0; ret_memwrite = 1'b0;
    ret_halt = 1'b0; ret_pc = 16'd0; ret_wdata = 16'd0; ret_addr = 16'd0;
    ret_mdata = 16'd0; ret_wreg = 3'd0;

    // REG then HALT, then a retire after halt
    do_reset();
    push_rec(3'd1, 16'h0000, 16'h0005, 16'h0, 16'h0, 3'd3);
    push_rec(3'd5, 16'h0002, 16'h0, 16'h0, 16'h0, 3'd0);
    retire(16'h0000, 16'h0005, 16'h0, 16'h0, 3'd3, 1, 0, 0, 0, mk(0, 0, 0, 16'h0, 1, 0, 0));
    retire(16'h0002, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1, mk(0, 0, 0, 16'h0, 2, 1, 1));
    retire(16'h0030, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, mk(1, 8, 2, 16'h0030, 2, 1, 0));
    chk("halt_cycle_count", cycle_count, 4);

    // Full FIFO, simultaneous push and pop, pointer wrap, then underflow
    do_reset();
    for (int i = 0; i < 8; i++) push_rec(3'd0, 16'(2 * i), 16'h0, 16'h0, 16'h0, 3'd0);
    exp_kind = 3'd0; exp_pc = 16'h0010; exp_valid = 1'b1;
    chk("full_ready", exp_ready, 0);
    retire(16'h0000, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, mk(0, 0, 0, 16'h0, 1, 0, 0));
    exp_valid = 1'b0;
    chk("full_after_swap_ready", exp_ready, 0);
    retire(16'h0002, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, mk(0, 0, 0, 16'h0, 2, 0, 0));
    chk("ready_after_pop", exp_ready, 1);
    for (int i = 2; i < 9; i++)
      retire(16'(2 * i), 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0,
             mk(0, 0, 0, 16'h0, 32'(i + 1), 0, 0));
    retire(16'h0050, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, mk(1, 1, 9, 16'h0050, 9, 0, 0));

    // Underflow with a same-cycle push: no bypass
    do_reset();
    exp_kind = 3'd1; exp_pc = 16'h0040; exp_reg = 3'd2; exp_val = 16'h0001; exp_valid = 1'b1;
    retire(16'h0040, 16'h0001, 16'h0, 16'h0, 3'd2, 1, 0, 0, 0, mk(1, 1, 0, 16'h0040, 0, 0, 0));
    exp_valid = 1'b0;

    // ST with pc and mdata wrong: pc wins; later retires change nothing
    do_reset();
    push_rec(3'd3, 16'h0010, 16'h0, 16'h0100, 16'hBEEF, 3'd0);
    retire(16'h0012, 16'h0, 16'h0100, 16'hBEEE, 3'd0, 0, 0, 1, 0,
           mk(1, 3, 0, 16'h0012, 0, 0, 0));
    push_rec(3'd3, 16'h0014, 16'h0, 16'h0100, 16'hBEEF, 3'd0);
    retire(16'h0014, 16'h0, 16'h0100, 16'hBEEF, 3'd0, 0, 0, 1, 0,
           mk(1, 3, 0, 16'h0012, 0, 0, 0));
    chk("error_cycle_frozen", cycle_count, 2);

    // Kind mismatch: PC-only expected, REG retired
    do_reset();
    push_rec(3'd0, 16'h0004, 16'h0, 16'h0, 16'h0, 3'd0);
    retire(16'h0004, 16'h0, 16'h0, 16'h0, 3'd0, 1, 0, 0, 0, mk(1, 2, 0, 16'h0004, 0, 0, 0));

    // LD ignores mdata; illegal expected kind is flagged
    do_reset();
    push_rec(3'd2, 16'h0020, 16'h1234, 16'h0200, 16'h0000, 3'd1);
    retire(16'h0020, 16'h1234, 16'h0200, 16'hFFFF, 3'd1, 1, 1, 0, 0,
           mk(0, 0, 0, 16'h0, 1, 0, 0));
    push_rec(3'd6, 16'h0022, 16'h0, 16'h0, 16'h0, 3'd0);
    retire(16'h0022, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, mk(1, 2, 1, 16'h0022, 1, 0, 0));

    // STU match, then REG with wreg and wdata wrong: wreg wins
    do_reset();
    push_rec(3'd4, 16'h0000, 16'hAAAA, 16'h0300, 16'h5555, 3'd2);
    push_rec(3'd1, 16'h0002, 16'h0007, 16'h0, 16'h0, 3'd4);
    retire(16'h0000, 16'hAAAA, 16'h0300, 16'h5555, 3'd2, 1, 0, 1, 0,
           mk(0, 0, 0, 16'h0, 1, 0, 0));
    retire(16'h0002, 16'h0008, 16'h0, 16'h0, 3'd5, 1, 0, 0, 0, mk(1, 4, 1, 16'h0002, 1, 0, 0));

    // Mid-run reset discards buffered records
    do_reset();
    push_rec(3'd0, 16'h0000, 16'h0, 16'h0, 16'h0, 3'd0);
    push_rec(3'd0, 16'h0002, 16'h0, 16'h0, 16'h0, 3'd0);
    do_reset();
    retire(16'h0000, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, mk(1, 1, 0, 16'h0000, 0, 0, 0));

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
